fifo_pkt_arb: RTL and testbench
===============================

Name: fifo_pkt_arb

Overview:
- Packet-granular round-robin arbiter sharing the external output-FIFO write port (of_d/of_wr/of_wrfull) between two requesters: CPU-side and hardware source.
- Also sequences the FIFO reset (fifo_rst) with a hold phase and a quiet phase, so no writes land during or just after reset.
- Sits between the Wishbone FIFO register device / hardware producers and the external FIFO.

Parameters:
LEN_W, 10, width of packet-length inputs; len==0 encodes 2**LEN_W words
RST_CYCLES, 4, cycles fifo_rst held high (min 1)
RST_QUIET, 8, cycles after fifo_rst deasserts with no grants (min 1)

Ports:
wb_clk  in  1  clock
wb_reset_n  in  1  asynchronous active-low reset
rst_req  in  1  single-cycle request to reset the external FIFO
req0  in  1  requester 0 packet request, level, held until gnt0
len0  in  LEN_W  requester 0 packet length in 32-bit words, sampled at grant
dat0  in  32  requester 0 data
vld0  in  1  requester 0 data valid
rdy0  out  1  requester 0 data accepted this cycle when vld0&rdy0
gnt0  out  1  requester 0 owns FIFO port
req1, len1, dat1, vld1, rdy1, gnt1  same as above for requester 1
of_d  out  32  data to output FIFO
of_wr  out  1  write strobe to output FIFO
of_wrfull  in  1  output FIFO full
fifo_rst  out  1  FIFO reset, active-high
busy  out  1  state != IDLE
pkt_done  out  1  one-cycle pulse after the last word of a packet

Behaviour:
- Reset (wb_reset_n low, async): state IDLE, all outputs 0 (gnt*, rdy*, of_wr, fifo_rst, busy, pkt_done), counter 0, rst_pend 0, last_served=1 (so requester 0 wins first).
- States: IDLE, XFER, RST_HOLD, RST_QUIET.
- rst_req sets rst_pend in any state except RST_HOLD/RST_QUIET; it is ignored in those two states.
- IDLE:
  - If rst_pend: go to RST_HOLD and clear rst_pend. Reset has priority over pending reqs.
  - Else if any req: grant the requester not equal to last_served when both request, otherwise the single requester.
  - On grant: latch its len into the remaining-word counter (0 -> 2**LEN_W) and go to XFER. gntX is registered, so it goes high the cycle after req is seen in IDLE.
- XFER:
  - rdyX = gntX & ~of_wrfull (combinational).
  - of_wr = gntX & vldX & ~of_wrfull.
  - of_d = dat of the granted requester, else 0.
  - Each beat (vld&rdy) decrements the counter.
  - On the beat with counter==1: next state IDLE, gnt drops next cycle, pkt_done pulses that same next cycle, last_served updated.
  - Deasserting req mid-packet has no effect; the packet completes only by word count.
  - of_wrfull stalls with no loss or duplication.
  - The non-granted requester's rdy is 0.
- Minimum gap between packets: one IDLE cycle, so the next gnt rises 2 cycles after the last beat.
- rst_req during XFER: the packet is not truncated; the reset runs after it completes via the IDLE cycle.
- RST_HOLD: fifo_rst=1 for exactly RST_CYCLES cycles (registered), then RST_QUIET.
- RST_QUIET: fifo_rst=0, no grants for RST_QUIET cycles, then IDLE.
- busy=1 in every state except IDLE.
- Counter width LEN_W+1, no wrap.

Test Plan:
- Single packet: req0=1, len0=3, vld0 always 1, of_wrfull=0 -> gnt0 rises 1 cycle after req0; 3 consecutive of_wr with of_d=dat0 values; pkt_done one cycle after the 3rd; gnt0 low.
- Round robin: req0=req1=1 held, len0=len1=2 -> grant order 0,1,0,1; exactly 2 writes each; one IDLE cycle between packets.
- Backpressure: len1=4, of_wrfull high for 3 cycles after the 2nd word -> rdy1=0 and of_wr=0 during the stall; exactly 4 writes total, data in order.
- Reset sequencing: rst_req pulse mid-packet (len0=5, at word 2) -> all 5 words written; then fifo_rst high for 4 cycles, 8 quiet cycles with req1 asserted and no gnt1, then gnt1.
- Zero length: LEN_W=3, len0=0 -> exactly 8 writes before pkt_done.
- Async reset: wb_reset_n low mid-XFER -> of_wr, gnt0, and busy go 0 immediately; after release, a new req0 is granted normally.

Source files
------------

// File: rtl/fifo_pkt_arb.sv
// Packet-granular round-robin arbiter for the output-FIFO write port, plus FIFO reset sequencing.
// Grant is registered (1 cycle after req in IDLE); of_wrfull stalls rdy/of_wr combinationally with no loss.
module fifo_pkt_arb #(
   parameter int LEN_W      = 10,
   parameter int RST_CYCLES = 4,
   parameter int RST_QUIET  = 8
) (
   input  logic             wb_clk,
   input  logic             wb_reset_n,
   input  logic             rst_req,
   input  logic             req0,
   input  logic [LEN_W-1:0] len0,
   input  logic [31:0]      dat0,
   input  logic             vld0,
   output logic             rdy0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [LEN_W-1:0] len1,
   input  logic [31:0]      dat1,
   input  logic             vld1,
   output logic             rdy1,
   output logic             gnt1,
   output logic [31:0]      of_d,
   output logic             of_wr,
   input  logic             of_wrfull,
   output logic             fifo_rst,
   output logic             busy,
   output logic             pkt_done
);

   localparam int TMR_MAX = (RST_CYCLES > RST_QUIET) ? RST_CYCLES : RST_QUIET;
   localparam int TMR_W   = $clog2(TMR_MAX) + 1;
   localparam logic [LEN_W:0]   CNT_ONE = (LEN_W+1)'(1);
   localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_RST_HOLD, S_RST_QUIET} state_t;

   state_t           r_state;
   logic             r_gnt0, r_gnt1;
   logic [LEN_W:0]   r_cnt;
   logic [TMR_W-1:0] r_tmr;
   logic             r_rst_pend;
   logic             r_last;
   logic             r_fifo_rst;
   logic             r_busy;
   logic             r_pkt_done;

   logic             w_beat0, w_beat1, w_beat;
   logic             w_pick1;
   logic [LEN_W-1:0] w_len;
   logic [LEN_W:0]   w_cnt_init;

   assign w_beat0 = r_gnt0 & vld0 & ~of_wrfull;
   assign w_beat1 = r_gnt1 & vld1 & ~of_wrfull;
   assign w_beat  = w_beat0 | w_beat1;

   // With both requesting, the one not served last wins; r_last resets to 1 so requester 0 goes first.
   assign w_pick1    = req1 & (~req0 | ~r_last);
   assign w_len      = w_pick1 ? len1 : len0;
   assign w_cnt_init = (w_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, w_len};

   assign rdy0     = r_gnt0 & ~of_wrfull;
   assign rdy1     = r_gnt1 & ~of_wrfull;
   assign gnt0     = r_gnt0;
   assign gnt1     = r_gnt1;
   assign of_wr    = w_beat;
   assign of_d     = r_gnt0 ? dat0 : (r_gnt1 ? dat1 : 32'h0);
   assign fifo_rst = r_fifo_rst;
   assign busy     = r_busy;
   assign pkt_done = r_pkt_done;

   always_ff @(posedge wb_clk or negedge wb_reset_n) begin
      if (!wb_reset_n) begin
         r_state    <= S_IDLE;
         r_gnt0     <= 1'b0;
         r_gnt1     <= 1'b0;
         r_cnt      <= '0;
         r_tmr      <= '0;
         r_rst_pend <= 1'b0;
         r_last     <= 1'b1;
         r_fifo_rst <= 1'b0;
         r_busy     <= 1'b0;
         r_pkt_done <= 1'b0;
      end else begin
         r_pkt_done <= 1'b0;
         if (rst_req && r_state != S_RST_HOLD && r_state != S_RST_QUIET)
            r_rst_pend <= 1'b1;
         case (r_state)
            S_IDLE: begin
               // A pending reset beats any waiting request; the clear overrides a same-cycle rst_req.
               if (r_rst_pend) begin
                  r_rst_pend <= 1'b0;
                  r_fifo_rst <= 1'b1;
                  r_busy     <= 1'b1;
                  r_tmr      <= TMR_W'(RST_CYCLES - 1);
                  r_state    <= S_RST_HOLD;
               end else if (req0 || req1) begin
                  r_gnt0  <= ~w_pick1;
                  r_gnt1  <= w_pick1;
                  r_cnt   <= w_cnt_init;
                  r_busy  <= 1'b1;
                  r_state <= S_XFER;
               end
            end
            S_XFER: begin
               if (w_beat) begin
                  r_cnt <= r_cnt - CNT_ONE;
                  if (r_cnt == CNT_ONE) begin
                     r_gnt0     <= 1'b0;
                     r_gnt1     <= 1'b0;
                     r_pkt_done <= 1'b1;
                     r_busy     <= 1'b0;
                     r_last     <= r_gnt1;
                     r_state    <= S_IDLE;
                  end
               end
            end
            S_RST_HOLD: begin
               if (r_tmr == '0) begin
                  r_fifo_rst <= 1'b0;
                  r_tmr      <= TMR_W'(RST_QUIET - 1);
                  r_state    <= S_RST_QUIET;
               end else begin
                  r_tmr <= r_tmr - TMR_ONE;
               end
            end
            S_RST_QUIET: begin
               if (r_tmr == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_tmr <= r_tmr - TMR_ONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_pkt_arb.sv
// Directed bench for fifo_pkt_arb (LEN_W=3): single packet, round robin, stall, reset sequencing, zero length, async reset.
module tb_fifo_pkt_arb;
   localparam int LEN_W = 3;

   logic             wb_clk = 1'b0;
   logic             wb_reset_n = 1'b0;
   logic             rst_req = 1'b0;
   logic             req0 = 1'b0, req1 = 1'b0;
   logic             vld0 = 1'b0, vld1 = 1'b0;
   logic             of_wrfull = 1'b0;
   logic [LEN_W-1:0] len0 = '0, len1 = '0;
   logic [31:0]      dat0 = '0, dat1 = '0;
   logic [31:0]      of_d;
   logic             rdy0, rdy1, gnt0, gnt1, of_wr, fifo_rst, busy, pkt_done;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [31:0] wq[$];
   int          wc[$];
   int          n_rst, n_g, n_busy;
   logic [31:0] exp_rr [8];

   always #5 wb_clk = ~wb_clk;

   fifo_pkt_arb #(.LEN_W(LEN_W), .RST_CYCLES(4), .RST_QUIET(8)) u_dut (
      .wb_clk(wb_clk), .wb_reset_n(wb_reset_n), .rst_req(rst_req),
      .req0(req0), .len0(len0), .dat0(dat0), .vld0(vld0), .rdy0(rdy0), .gnt0(gnt0),
      .req1(req1), .len1(len1), .dat1(dat1), .vld1(vld1), .rdy1(rdy1), .gnt1(gnt1),
      .of_d(of_d), .of_wr(of_wr), .of_wrfull(of_wrfull),
      .fifo_rst(fifo_rst), .busy(busy), .pkt_done(pkt_done)
   );

   always @(negedge wb_clk) begin
      if (of_wr) begin
         wq.push_back(of_d);
         wc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Sources advance their data word on every accepted beat.
   task automatic tick();
      logic b0, b1;
      #1;
      b0 = vld0 & rdy0;
      b1 = vld1 & rdy1;
      @(posedge wb_clk);
      #1;
      cyc++;
      if (b0) dat0 = dat0 + 32'd1;
      if (b1) dat1 = dat1 + 32'd1;
   endtask

   task automatic chk_wr(input string tag, input int n, input logic [31:0] base);
      chk({tag, "_nwr"}, wq.size(), n);
      for (int i = 0; i < n; i++)
         chk({tag, "_dat"}, (i < wq.size()) ? wq[i] : 32'hDEADBEEF, base + i);
   endtask

   task automatic clr();
      wq.delete();
      wc.delete();
   endtask

   task automatic do_reset();
      wb_reset_n = 1'b0;
      tick();
      tick();
      wb_reset_n = 1'b1;
      tick();
   endtask

   initial begin
      vld0 = 1'b1;
      vld1 = 1'b1;
      #1;
      chk("rst_outs", {24'h0, gnt0, gnt1, rdy0, rdy1, of_wr, fifo_rst, busy, pkt_done}, 32'h0);
      chk("rst_of_d", of_d, 32'h0);
      tick();
      tick();
      wb_reset_n = 1'b1;
      tick();

      // single packet of 3 words
      clr();
      dat0 = 32'hA000; len0 = 3; req0 = 1'b1;
      #1;
      chk("t1_gnt_pre", gnt0, 1'b0);
      tick();
      chk("t1_gnt", gnt0, 1'b1);
      chk("t1_busy", busy, 1'b1);
      req0 = 1'b0;
      tick(); tick(); tick();
      chk("t1_done", pkt_done, 1'b1);
      chk("t1_gnt_off", gnt0, 1'b0);
      tick();
      chk("t1_done_off", pkt_done, 1'b0);
      chk_wr("t1", 3, 32'hA000);

      // round robin, both requesting, 2 words each
      do_reset();
      clr();
      dat0 = 32'hB000; dat1 = 32'hC000; len0 = 2; len1 = 2;
      req0 = 1'b1; req1 = 1'b1;
      repeat (11) tick();
      req0 = 1'b0; req1 = 1'b0;
      repeat (3) tick();
      exp_rr = '{32'hB000, 32'hB001, 32'hC000, 32'hC001, 32'hB002, 32'hB003, 32'hC002, 32'hC003};
      chk("t2_nwr", wq.size(), 8);
      for (int i = 0; i < 8; i++)
         chk("t2_order", (i < wq.size()) ? wq[i] : 32'hDEADBEEF, exp_rr[i]);
      chk("t2_b2b", (wc.size() >= 3) ? wc[1] - wc[0] : -1, 1);
      chk("t2_gap", (wc.size() >= 3) ? wc[2] - wc[1] : -1, 2);

      // backpressure: 3 full cycles after the 2nd word
      clr();
      dat1 = 32'hD000; len1 = 4; req1 = 1'b1;
      tick();
      chk("t3_gnt", gnt1, 1'b1);
      chk("t3_rdy0_off", rdy0, 1'b0);
      req1 = 1'b0;
      tick(); tick();
      of_wrfull = 1'b1;
      #1;
      chk("t3_stall_rdy", rdy1, 1'b0);
      chk("t3_stall_wr", of_wr, 1'b0);
      tick();
      chk("t3_stall_rdy2", rdy1, 1'b0);
      chk("t3_stall_wr2", of_wr, 1'b0);
      tick(); tick();
      chk("t3_busy", busy, 1'b1);
      of_wrfull = 1'b0;
      tick(); tick();
      chk("t3_done", pkt_done, 1'b1);
      tick();
      chk_wr("t3", 4, 32'hD000);
      chk("t3_stall_gap", (wc.size() >= 3) ? wc[2] - wc[1] : -1, 4);

      // reset request mid-packet, then hold/quiet with req1 waiting
      clr();
      dat0 = 32'hE000; len0 = 5; req0 = 1'b1;
      tick();
      req0 = 1'b0;
      tick();
      rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      tick(); tick(); tick();
      chk("t4_done", pkt_done, 1'b1);
      chk("t4_no_rst_yet", fifo_rst, 1'b0);
      chk_wr("t4", 5, 32'hE000);
      req1 = 1'b1; len1 = 1; dat1 = 32'hF000;
      n_rst = 0; n_g = 0; n_busy = 0;
      for (int i = 0; i < 13; i++) begin
         if (i == 5) rst_req = 1'b1;
         tick();
         rst_req = 1'b0;
         if (i == 0) chk("t4_rst_first", fifo_rst, 1'b1);
         n_rst += int'(fifo_rst);
         n_g += int'(gnt1);
         n_busy += int'(busy);
      end
      chk("t4_rst_cycles", n_rst, 4);
      chk("t4_quiet_nognt", n_g, 0);
      chk("t4_busy_cycles", n_busy, 12);
      chk("t4_idle", busy, 1'b0);
      tick();
      chk("t4_gnt1", gnt1, 1'b1);
      req1 = 1'b0;
      tick();
      chk("t4_done1", pkt_done, 1'b1);
      tick();
      chk("t4_nwr_all", wq.size(), 6);
      chk("t4_last_dat", (wq.size() == 6) ? wq[5] : 32'hDEADBEEF, 32'hF000);

      // zero length means 8 words at LEN_W=3
      clr();
      dat0 = 32'h9000; len0 = 0; req0 = 1'b1;
      tick();
      req0 = 1'b0;
      repeat (7) tick();
      chk("t5_not_done", pkt_done, 1'b0);
      tick();
      chk("t5_done", pkt_done, 1'b1);
      tick();
      chk_wr("t5", 8, 32'h9000);

      // async reset mid-packet
      clr();
      dat0 = 32'h7000; len0 = 5; req0 = 1'b1;
      tick();
      req0 = 1'b0;
      tick();
      chk("t6_mid_wr", of_wr, 1'b1);
      wb_reset_n = 1'b0;
      #1;
      chk("t6_wr_off", of_wr, 1'b0);
      chk("t6_gnt_off", gnt0, 1'b0);
      chk("t6_busy_off", busy, 1'b0);
      tick(); tick();
      wb_reset_n = 1'b1;
      tick();
      chk("t6_idle", busy, 1'b0);
      req0 = 1'b1; len0 = 1;
      tick();
      chk("t6_regnt", gnt0, 1'b1);
      req0 = 1'b0;
      tick();
      chk("t6_done", pkt_done, 1'b1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
